// File: rtl/switch_scan_ctrl_pkg.sv
// Shared register map, control bit positions and scan FSM encoding.
package switch_scan_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_STATE  = 2'd2;
    localparam logic [1:0] REG_EDGE   = 2'd3;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_TRIG   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ADDR,
        ST_CAPT,
        ST_EVAL
    } scan_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Per-poll debounce: a sample must repeat STABLE_N times before it becomes
// the debounced value; emits a one-cycle change vector on acceptance.
module switch_debounce #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned STABLE_N = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] debounced,
    output logic [DATA_W-1:0] change
);

    localparam int unsigned SC_W = $clog2(STABLE_N + 1);
    localparam logic [SC_W-1:0] STABLE_MAX = SC_W'(STABLE_N);

    logic [DATA_W-1:0] candidate;
    logic [DATA_W-1:0] cand_next;
    logic [SC_W-1:0]   stable_cnt;
    logic [SC_W-1:0]   cnt_next;
    logic              accept;

    // Next candidate/count; acceptance is judged on the updated count so
    // STABLE_N=1 accepts on the first differing sample.
    always_comb begin
        cand_next = candidate;
        cnt_next  = stable_cnt;
        if (sample != candidate) begin
            cand_next = sample;
            cnt_next  = SC_W'(1);
        end else if (stable_cnt < STABLE_MAX) begin
            cnt_next = stable_cnt + 1'b1;
        end
        accept = sample_valid && (cnt_next == STABLE_MAX) && (cand_next != debounced);
        change = accept ? (debounced ^ cand_next) : '0;
    end

    // Debounce state updates only on a valid evaluated sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            candidate  <= '0;
            stable_cnt <= '0;
            debounced  <= '0;
        end else if (sample_valid) begin
            candidate  <= cand_next;
            stable_cnt <= cnt_next;
            if (accept) begin
                debounced <= cand_next;
            end
        end
    end

endmodule

// File: rtl/switch_scan_ctrl.sv
// Autonomous slide-switch scanner: polls the PIO data register, debounces,
// and exposes debounced state, edge capture and an IRQ on an Avalon slave.
module switch_scan_ctrl
    import switch_scan_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W         = 18,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned STABLE_N       = 4,
    parameter int unsigned DEFAULT_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    input  logic [31:0] m_readdata
);

    scan_state_e       state;
    scan_state_e       state_next;
    logic              ctrl_en;
    logic              ctrl_irq_en;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  period_eff;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [DATA_W-1:0] debounced;
    logic [DATA_W-1:0] change;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] edge_clr;
    logic [31:0]       rd_mux;
    logic              wr;
    logic              wr_ctrl;
    logic              trig_wr;
    logic              en_clear;
    logic              unused_bits;

    assign wr         = s_chipselect && !s_write_n;
    assign wr_ctrl    = wr && (s_address == REG_CTRL);
    assign trig_wr    = wr_ctrl && s_writedata[CTRL_TRIG];
    assign en_clear   = wr_ctrl && !s_writedata[CTRL_EN] && ctrl_en;
    assign edge_clr   = (wr && (s_address == REG_EDGE)) ? s_writedata[DATA_W-1:0] : '0;
    assign period_eff = (period == '0) ? CNT_W'(1) : period;
    assign irq        = ctrl_irq_en && (|edge_q);
    assign m_address  = '0;
    assign unused_bits = ^{s_writedata, m_readdata};

    // Scan FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, PIO strobe and sample qualification; clearing EN aborts
    // the scan from any state and discards the pending sample.
    always_comb begin
        state_next   = state;
        m_chipselect = 1'b0;
        sample_valid = 1'b0;
        case (state)
            ST_IDLE: if (ctrl_en || trig_wr) state_next = ST_WAIT;
            ST_WAIT: if (wait_cnt == '0) state_next = ST_ADDR;
            ST_ADDR: begin
                m_chipselect = 1'b1;
                state_next   = ST_CAPT;
            end
            ST_CAPT: state_next = ST_EVAL;
            ST_EVAL: begin
                sample_valid = 1'b1;
                state_next   = ctrl_en ? ST_WAIT : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (en_clear) begin
            state_next   = ST_IDLE;
            sample_valid = 1'b0;
        end
    end

    // Poll interval counter, reloaded from PERIOD only on WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if ((state_next == ST_WAIT) && (state != ST_WAIT)) begin
            wait_cnt <= period_eff - 1'b1;
        end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Capture the PIO read data one cycle after the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample <= '0;
        end else if (state == ST_CAPT) begin
            sample <= m_readdata[DATA_W-1:0];
        end
    end

    switch_debounce #(
        .DATA_W  (DATA_W),
        .STABLE_N(STABLE_N)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .debounced   (debounced),
        .change      (change)
    );

    // Software-visible control registers; new edges win over W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            period      <= CNT_W'(DEFAULT_PERIOD);
            edge_q      <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= s_writedata[CTRL_EN];
                ctrl_irq_en <= s_writedata[CTRL_IRQ_EN];
            end
            if (wr && (s_address == REG_PERIOD)) begin
                period <= s_writedata[CNT_W-1:0];
            end
            edge_q <= (edge_q & ~edge_clr) | change;
        end
    end

    // Read data select.
    always_comb begin
        rd_mux = '0;
        case (s_address)
            REG_CTRL:   rd_mux = {30'd0, ctrl_irq_en, ctrl_en};
            REG_PERIOD: rd_mux = 32'(period);
            REG_STATE:  rd_mux = 32'(debounced);
            REG_EDGE:   rd_mux = 32'(edge_q);
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_readdata <= '0;
        end else begin
            s_readdata <= s_chipselect ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Directed bench for switch_scan_ctrl with a registered PIO model and a
// read-data scoreboard.
module tb_switch_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic [31:0] m_readdata;
    logic [17:0] in_port;
    logic [17:0] bounce_seq [0:6];

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    logic [31:0] exp_q [$];

    switch_scan_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_address   (s_address),
        .s_chipselect(s_chipselect),
        .s_write_n   (s_write_n),
        .s_writedata (s_writedata),
        .s_readdata  (s_readdata),
        .irq         (irq),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_readdata  (m_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PIO data register model: registered readdata, one-cycle latency.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_readdata <= '0;
        else if (m_chipselect && (m_address == 2'd0)) m_readdata <= {14'd0, in_port};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        s_address    = addr;
        s_writedata  = data;
        @(negedge clk);
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic read_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        s_chipselect = 1'b1;
        s_write_n    = 1'b1;
        s_address    = addr;
        @(negedge clk);
        s_chipselect = 1'b0;
        check(tag, s_readdata, exp_q.pop_front());
    endtask

    task automatic wait_poll(output int unsigned t);
        bit seen = 1'b0;
        t = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (m_chipselect) begin
                seen = 1'b1;
                t = cyc;
                check("poll_m_address", 32'(m_address), 32'd0);
            end
        end
        check("poll_seen", 32'(seen), 32'd1);
    endtask

    task automatic no_poll(input string tag, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (m_chipselect) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int unsigned t;
        int unsigned tprev;
        reset_n = 1'b0;
        s_address = '0;
        s_chipselect = 1'b0;
        s_write_n = 1'b1;
        s_writedata = '0;
        in_port = '0;
        bounce_seq[0] = 18'h1; bounce_seq[1] = 18'h0; bounce_seq[2] = 18'h1;
        bounce_seq[3] = 18'h1; bounce_seq[4] = 18'h1; bounce_seq[5] = 18'h1;
        bounce_seq[6] = 18'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state held while idle.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rst_readdata", s_readdata, 32'd0);
            check("rst_irq", 32'(irq), 32'd0);
            check("rst_m_chipselect", 32'(m_chipselect), 32'd0);
        end
        read_reg("rst_period", 2'd1, 32'd50000);
        read_reg("rst_ctrl", 2'd0, 32'd0);
        read_reg("rst_state", 2'd2, 32'd0);
        read_reg("rst_edge", 2'd3, 32'd0);

        // Stuck input 0x5, PERIOD=4: poll every 7 cycles, accept on 4th poll.
        write_reg(2'd1, 32'd4);
        read_reg("period_rb", 2'd1, 32'd4);
        in_port = 18'h5;
        write_reg(2'd0, 32'h1);
        tprev = 0;
        for (int p = 1; p <= 4; p++) begin
            wait_poll(t);
            if (p > 1) check("cadence_p4", t - tprev, 32'd7);
            tprev = t;
            @(negedge clk);
            check("cs_width", 32'(m_chipselect), 32'd0);
            @(negedge clk);
            @(negedge clk);
            read_reg("stuck_state", 2'd2, (p == 4) ? 32'h5 : 32'h0);
        end
        read_reg("stuck_edge", 2'd3, 32'h5);
        check("irq_disabled", 32'(irq), 32'd0);
        write_reg(2'd0, 32'h3);
        check("irq_enabled", 32'(irq), 32'd1);
        read_reg("ctrl_rb", 2'd0, 32'h3);

        // W1C partial and full clear.
        write_reg(2'd3, 32'h1);
        read_reg("w1c_edge", 2'd3, 32'h4);
        check("w1c_irq_held", 32'(irq), 32'd1);
        write_reg(2'd3, 32'h4);
        check("w1c_irq_clr", 32'(irq), 32'd0);

        // Input 0x4: on the accepting EVAL, clear bit 0 in the same cycle.
        wait_poll(t);
        @(negedge clk);
        in_port = 18'h4;
        for (int k = 1; k <= 4; k++) wait_poll(t);
        @(negedge clk);
        @(negedge clk);
        write_reg(2'd3, 32'h1);
        read_reg("setwins_edge", 2'd3, 32'h1);
        read_reg("setwins_state", 2'd2, 32'h4);
        check("setwins_irq", 32'(irq), 32'd1);

        // Async reset in CAPT clears everything before the next edge.
        wait_poll(t);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("areset_irq", 32'(irq), 32'd0);
        check("areset_cs", 32'(m_chipselect), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        read_reg("areset_state", 2'd2, 32'd0);
        read_reg("areset_edge", 2'd3, 32'd0);
        read_reg("areset_period", 2'd1, 32'd50000);
        read_reg("areset_ctrl", 2'd0, 32'd0);

        // Bounce: 1,0,1,1,1,1 accepted only after the 6th poll.
        write_reg(2'd1, 32'd4);
        in_port = bounce_seq[0];
        write_reg(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) begin
            wait_poll(t);
            @(negedge clk);
            in_port = bounce_seq[k+1];
            @(negedge clk);
            @(negedge clk);
            read_reg("bounce_state", 2'd2, (k == 5) ? 32'h1 : 32'h0);
            read_reg("bounce_edge", 2'd3, (k == 5) ? 32'h1 : 32'h0);
        end

        // Three stable polls of 0, then clear EN during the 4th ADDR.
        for (int k = 1; k <= 3; k++) wait_poll(t);
        wait_poll(t);
        write_reg(2'd0, 32'h0);
        no_poll("en_clr_idle", 30);
        read_reg("en_clr_state", 2'd2, 32'h1);
        read_reg("en_clr_edge", 2'd3, 32'h1);
        write_reg(2'd3, 32'h1);
        read_reg("edge_cleared", 2'd3, 32'h0);

        // TRIG with EN=0: exactly one poll, which completes the count.
        write_reg(2'd0, 32'h4);
        wait_poll(t);
        no_poll("trig_single", 40);
        read_reg("trig_state", 2'd2, 32'h0);
        read_reg("trig_edge", 2'd3, 32'h1);
        read_reg("trig_ctrl", 2'd0, 32'h0);

        // PERIOD=0 behaves as 1: poll every 4 cycles.
        write_reg(2'd1, 32'd0);
        write_reg(2'd0, 32'h1);
        wait_poll(tprev);
        wait_poll(t);
        check("cadence_p0", t - tprev, 32'd4);
        read_reg("period0_rb", 2'd1, 32'd0);
        write_reg(2'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
